data_mem_ctrl: RTL and testbench

Parametrised, single-port, synchronous data memory for the CPU load/store stage, replacing the flat word-only RAM. Adds byte/halfword/word access with RV32 `funct3` encoding, little-endian byte lanes, load sign/zero extension, a valid/ready request channel with a registered one-cycle response, and error reporting for misaligned, out-of-range or illegal accesses. An optional FSM zeroes the array after reset, one word per cycle.

---
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/data_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the load/store stage (master) and data_mem_ctrl (slave).
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory with RV32 funct3 sizing and error reporting; DMEM_CLEAR_EN adds a post-reset zeroing FSM.
// Latency: response registered one cycle after the accepting edge; one request per cycle.
// Backpressure: req_ready low only during reset or the clear sequence, never dependent on req_valid.
module data_mem_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]       mem [DEPTH_WORDS];
  logic              run;
  logic              accept;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              err;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_dat;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_dat;

`ifdef DMEM_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] clr_cnt;
  logic             clr_we;

  assign run    = (state == ST_RUN);
  assign clr_we = (state == ST_CLEAR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IDX_W'(DEPTH_WORDS - 1))
        state <= ST_RUN;
    end
  end

  assign bus.busy = (state == ST_CLEAR);
`else
  assign run      = 1'b1;
  assign bus.busy = 1'b0;
`endif

  assign bus.req_ready = run && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  assign offset = bus.req_addr - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];
  assign lane   = offset[1:0];

  always_comb begin
    err = 1'b0;
    if (offset >= ADDR_W'(DEPTH_WORDS * 4))                     err = 1'b1;
    if (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11) err = 1'b1;
    if (bus.req_funct3[2] && bus.req_we)                         err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && lane[0])                 err = 1'b1;
    if (bus.req_funct3 == 3'b010 && lane != 2'b00)               err = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_be  = 4'b0000;
    wr_dat = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        wr_be  = 4'b0001 << lane;
        wr_dat = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be  = lane[1] ? 4'b1100 : 4'b0011;
        wr_dat = {2{bus.req_wdata[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  assign wr_en = accept && bus.req_we && !err;

  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (clr_we)
      mem[clr_cnt] <= '0;
    else
`endif
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_dat[8*i +: 8];
    end
  end

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    case (bus.req_funct3)
      3'b000:  ld_dat = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_dat = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ld_dat = rd_shift;
      3'b100:  ld_dat = {24'd0, rd_shift[7:0]};
      3'b101:  ld_dat = {16'd0, rd_shift[15:0]};
      default: ld_dat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_rdata <= (accept && !bus.req_we && !err) ? ld_dat : 32'd0;
      bus.rsp_err   <= accept && err;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: byte lanes, extension, errors, back-to-back and reset/clear behaviour.
module tb_data_mem_ctrl;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  data_mem_ctrl_if #(.ADDR_W(32)) bus ();

  data_mem_ctrl #(
    .ADDR_W(32),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One request, sampled #1 after its accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic rv, output logic [31:0] rd,
                       output logic re);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    rv = bus.rsp_valid;
    rd = bus.rsp_rdata;
    re = bus.rsp_err;
    bus.req_valid = 1'b0;
  endtask

  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] off,
                       input logic [31:0] wdata, input logic exp_err);
    logic rv, re;
    logic [31:0] rd;
    issue(1'b1, f3, BASE + off, wdata, rv, rd, re);
    check({tag, "_v"}, 32'(rv), 32'd1);
    check({tag, "_e"}, 32'(re), 32'(exp_err));
    check({tag, "_d"}, rd, 32'd0);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] off,
                      input logic [31:0] exp_dat, input logic exp_err);
    logic rv, re;
    logic [31:0] rd;
    issue(1'b0, f3, BASE + off, 32'd0, rv, rd, re);
    check({tag, "_v"}, 32'(rv), 32'd1);
    check({tag, "_e"}, 32'(re), 32'(exp_err));
    check({tag, "_d"}, rd, exp_dat);
  endtask

  // Counts busy cycles starting at the current sample point; rsp_valid must stay low.
  task automatic count_busy(input string tag, output int cycles);
    int rv_seen;
    cycles  = 0;
    rv_seen = 0;
    while (bus.busy && cycles < 100) begin
      if (bus.rsp_valid) rv_seen++;
      cycles++;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check({tag, "_rv_quiet"}, 32'(rv_seen), 32'd0);
  endtask

  initial begin
    int cyc;
    logic rv, re;
    logic [31:0] rd;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = BASE;
    bus.req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    #1;

`ifdef DMEM_CLEAR_EN
    check("clr_ready_low", 32'(bus.req_ready), 32'd0);
    count_busy("clr", cyc);
    check("clr_busy_cycles", 32'(cyc), 32'(DEPTH));
    check("clr_ready_after", 32'(bus.req_ready), 32'd1);
    load("clr_lw3c", 3'b010, 32'h3C, 32'd0, 1'b0);
`else
    check("nclr_busy", 32'(bus.busy), 32'd0);
    check("nclr_ready", 32'(bus.req_ready), 32'd1);
`endif

    // Byte lanes
    store("sw8", 3'b010, 32'h8, 32'h1122_3344, 1'b0);
    store("sb9", 3'b000, 32'h9, 32'h0000_00AA, 1'b0);
    load("lw8", 3'b010, 32'h8, 32'h1122_AA44, 1'b0);
    load("lb9", 3'b000, 32'h9, 32'hFFFF_FFAA, 1'b0);
    load("lbu9", 3'b100, 32'h9, 32'h0000_00AA, 1'b0);
    load("lbB", 3'b000, 32'hB, 32'h0000_0011, 1'b0);
    load("lhA", 3'b001, 32'hA, 32'h0000_1122, 1'b0);

    // Halfword extension
    store("sw4", 3'b010, 32'h4, 32'hCAFE_0000, 1'b0);
    store("sh6", 3'b001, 32'h6, 32'h0000_8001, 1'b0);
    load("lh6", 3'b001, 32'h6, 32'hFFFF_8001, 1'b0);
    load("lhu6", 3'b101, 32'h6, 32'h0000_8001, 1'b0);
    load("lw4", 3'b010, 32'h4, 32'h8001_0000, 1'b0);

    // Errors
    store("sw0", 3'b010, 32'h0, 32'h0BAD_F00D, 1'b0);
    load("err_lw2", 3'b010, 32'h2, 32'd0, 1'b1);
    store("err_sh5", 3'b001, 32'h5, 32'h0000_FFFF, 1'b1);
    load("err_f011", 3'b011, 32'h8, 32'd0, 1'b1);
    store("err_sbu", 3'b100, 32'h8, 32'h0000_0055, 1'b1);
    store("err_oor", 3'b010, 32'(DEPTH * 4), 32'h5555_5555, 1'b1);
    load("err_below", 3'b010, 32'hFFFF_FFFC, 32'd0, 1'b1);
    load("post_lw0", 3'b010, 32'h0, 32'h0BAD_F00D, 1'b0);
    load("post_lw4", 3'b010, 32'h4, 32'h8001_0000, 1'b0);
    load("post_lw8", 3'b010, 32'h8, 32'h1122_AA44, 1'b0);

    // Back-to-back store then load of the same word
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = BASE + 32'h10;
    bus.req_wdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("b2b_v1", 32'(bus.rsp_valid), 32'd1);
    check("b2b_d1", bus.rsp_rdata, 32'd0);
    bus.req_we = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_v2", 32'(bus.rsp_valid), 32'd1);
    check("b2b_d2", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("b2b_e2", 32'(bus.rsp_err), 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_v3", 32'(bus.rsp_valid), 32'd0);
    check("b2b_d3", bus.rsp_rdata, 32'd0);

    // Reset while a load is pending; clear build also restarts mid-clear
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = BASE + 32'h8;
    reset          = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_rv", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
`ifdef DMEM_CLEAR_EN
    repeat (7) begin
      @(posedge clk);
      #1;
      check("mid_rv", 32'(bus.rsp_valid), 32'd0);
    end
    check("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    count_busy("reclr", cyc);
    check("reclr_busy_cycles", 32'(cyc), 32'(DEPTH));
    load("reclr_lw8", 3'b010, 32'h8, 32'd0, 1'b0);
`else
    bus.req_valid = 1'b0;
    load("retain_lw8", 3'b010, 32'h8, 32'h1122_AA44, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
